// File: rtl/bus_transfer_controller_pkg.sv
// Shared definitions for the bus transfer controller: FSM encoding, RW polarity
// and the request legality rule.
package bus_transfer_controller_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    localparam logic RW_DRIVE = 1'b1;
    localparam logic RW_LOAD  = 1'b0;

    // A register-to-register move needs two distinct, existing registers.
    function automatic logic req_legal(input int unsigned src, input int unsigned dst,
                                       input logic imm_en, input int unsigned num_regs);
        return (dst < num_regs) && (imm_en || ((src < num_regs) && (src != dst)));
    endfunction

endpackage

// File: rtl/bus_transfer_controller_if.sv
// Request handshake and per-register strobe bundle between a requester (master)
// and the bus transfer controller (slave).
interface bus_transfer_controller_if #(
    parameter int unsigned BUS_WIDTH = 16,
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned SEL_WIDTH = 3
);
    logic                 REQ_VALID;
    logic                 REQ_READY;
    logic [SEL_WIDTH-1:0] REQ_SRC;
    logic [SEL_WIDTH-1:0] REQ_DST;
    logic                 REQ_IMM_EN;
    logic [BUS_WIDTH-1:0] REQ_IMM;
    logic                 REQ_INC;
    logic [NUM_REGS-1:0]  REG_ENABLE;
    logic [NUM_REGS-1:0]  REG_RW;
    logic [NUM_REGS-1:0]  REG_COUNT;
    logic                 DONE;
    logic                 ERROR;
    logic [BUS_WIDTH-1:0] LAST_DATA;

    modport master (
        output REQ_VALID, REQ_SRC, REQ_DST, REQ_IMM_EN, REQ_IMM, REQ_INC,
        input  REQ_READY, REG_ENABLE, REG_RW, REG_COUNT, DONE, ERROR, LAST_DATA
    );

    modport slave (
        input  REQ_VALID, REQ_SRC, REQ_DST, REQ_IMM_EN, REQ_IMM, REQ_INC,
        output REQ_READY, REG_ENABLE, REG_RW, REG_COUNT, DONE, ERROR, LAST_DATA
    );
endinterface

// File: rtl/bus_transfer_controller_onehot_decoder.sv
// Register index to one-hot select; indices at or beyond NUM_REGS decode to zero.
module onehot_decoder #(
    parameter int unsigned SEL_WIDTH = 3,
    parameter int unsigned NUM_REGS  = 8
) (
    input  logic [SEL_WIDTH-1:0] sel_i,
    input  logic                 en_i,
    output logic [NUM_REGS-1:0]  onehot_o
);
    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (en_i && (32'(sel_i) == i)) onehot_o[i] = 1'b1;
        end
    end
endmodule

// File: rtl/bus_transfer_controller.sv
// Bus initiator: sequences per-register ENABLE/RW strobes so exactly one source
// drives DATA while one destination loads it, with optional source post-increment.
module bus_transfer_controller
    import bus_transfer_controller_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 16,
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned SEL_WIDTH = 3
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    bus_transfer_controller_if.slave bus,
    inout  wire  [BUS_WIDTH-1:0]     DATA
);
    state_e               state_q;
    logic [NUM_REGS-1:0]  src_oh_q, dst_oh_q;
    logic [NUM_REGS-1:0]  src_oh_d, dst_oh_d;
    logic [NUM_REGS-1:0]  en_q, rw_q, cnt_q;
    logic [BUS_WIDTH-1:0] imm_q, last_q;
    logic                 drive_q, inc_q, done_q, err_q, ready_q;
    logic                 req_ok;

    onehot_decoder #(.SEL_WIDTH(SEL_WIDTH), .NUM_REGS(NUM_REGS)) u_src_dec (
        .sel_i    (bus.REQ_SRC),
        .en_i     (~bus.REQ_IMM_EN),
        .onehot_o (src_oh_d)
    );

    onehot_decoder #(.SEL_WIDTH(SEL_WIDTH), .NUM_REGS(NUM_REGS)) u_dst_dec (
        .sel_i    (bus.REQ_DST),
        .en_i     (1'b1),
        .onehot_o (dst_oh_d)
    );

    assign req_ok = req_legal(32'(bus.REQ_SRC), 32'(bus.REQ_DST), bus.REQ_IMM_EN, NUM_REGS);

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q  <= IDLE;
            src_oh_q <= '0;
            dst_oh_q <= '0;
            imm_q    <= '0;
            inc_q    <= 1'b0;
            drive_q  <= 1'b0;
            en_q     <= '0;
            rw_q     <= {NUM_REGS{RW_DRIVE}};
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            last_q   <= '0;
            ready_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.REQ_VALID) begin
                        if (req_ok) begin
                            src_oh_q <= src_oh_d;
                            dst_oh_q <= dst_oh_d;
                            imm_q    <= bus.REQ_IMM;
                            inc_q    <= bus.REQ_INC;
                            drive_q  <= bus.REQ_IMM_EN;
                            en_q     <= src_oh_d;
                            rw_q     <= {NUM_REGS{RW_DRIVE}};
                            ready_q  <= 1'b0;
                            state_q  <= DRIVE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    en_q <= src_oh_q | dst_oh_q;
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        rw_q[i] <= dst_oh_q[i] ? RW_LOAD : RW_DRIVE;
                    end
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    last_q  <= DATA;
                    en_q    <= '0;
                    rw_q    <= {NUM_REGS{RW_DRIVE}};
                    drive_q <= 1'b0;
                    done_q  <= 1'b1;
                    cnt_q   <= inc_q ? src_oh_q : '0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes and the bus drive are masked by RESET directly so that a reset
    // asserted mid-transfer stops the destination load at the very next edge.
    assign bus.REG_ENABLE = en_q & {NUM_REGS{RESET}};
    assign bus.REG_RW     = rw_q | {NUM_REGS{~RESET}};
    assign bus.REG_COUNT  = cnt_q & {NUM_REGS{RESET}};
    assign bus.DONE       = done_q & RESET;
    assign bus.ERROR      = err_q & RESET;
    assign bus.LAST_DATA  = RESET ? last_q : '0;
    assign bus.REQ_READY  = ready_q;
    assign DATA           = (drive_q && RESET) ? imm_q : 'z;

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Self-checking bench: table-driven directed transfers, randomized transfers
// against a register-file model, back-to-back and mid-transfer reset sequences.
module tb_bus_transfer_controller;
    localparam int BW = 16;
    localparam int NR = 8;
    localparam int SW = 4;

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;
    wire [BW-1:0] DATA;

    int total = 0;
    int bad = 0;
    int mon_bad = 0;

    logic [15:0] regs   [NR];
    logic [15:0] preval [NR];
    logic [15:0] mregs  [NR];
    logic        preload = 1'b0;

    always #5 CLOCK = ~CLOCK;

    bus_transfer_controller_if #(.BUS_WIDTH(BW), .NUM_REGS(NR), .SEL_WIDTH(SW)) bif ();

    bus_transfer_controller #(.BUS_WIDTH(BW), .NUM_REGS(NR), .SEL_WIDTH(SW)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bif),
        .DATA  (DATA)
    );

    // Bus registers sitting on DATA
    always @(posedge CLOCK) begin
        for (int i = 0; i < NR; i++) begin
            if (preload) regs[i] <= preval[i];
            else if (bif.REG_ENABLE[i] && !bif.REG_RW[i]) regs[i] <= DATA;
            else if (bif.REG_COUNT[i]) regs[i] <= regs[i] + 16'd1;
        end
    end

    for (genvar g = 0; g < NR; g++) begin : g_busreg
        assign DATA = (bif.REG_ENABLE[g] && bif.REG_RW[g]) ? regs[g] : 'z;
    end

    always @(negedge CLOCK) begin
        if (($countones(bif.REG_ENABLE & bif.REG_RW) > 1) ||
            ($countones(bif.REG_ENABLE & ~bif.REG_RW) > 1))
            mon_bad <= mon_bad + 1;
    end

    typedef struct {
        logic [3:0]  s, d;
        logic        ie;
        logic [15:0] iv;
        logic        inc;
        logic        err;
        logic [7:0]  en1, en2, rw2, cnt3;
        logic [15:0] bus;
        logic [3:0]  cidx;
        logic [15:0] cval;
    } vec_t;

    typedef struct {
        logic        err, rdy1, idle3;
        logic [2:0]  done;
        logic [7:0]  en1, en2, rw2, cnt3;
        logic [15:0] bus1, bus2, last3;
    } obs_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit bus_idle(input logic [15:0] v);
        return $isunknown(v) || (v == 16'h0000);
    endfunction

    task automatic model_xfer(input logic [3:0] s, input logic [3:0] d, input logic ie,
                              input logic [15:0] iv, input logic inc,
                              output logic rej, output logic [15:0] val);
        rej = (int'(d) >= NR) || (!ie && ((int'(s) >= NR) || (s == d)));
        val = '0;
        if (!rej) begin
            val = ie ? iv : mregs[s[2:0]];
            mregs[d[2:0]] = val;
            if (inc && !ie) mregs[s[2:0]] = mregs[s[2:0]] + 16'd1;
        end
    endtask

    task automatic load_regs();
        preload = 1'b1;
        @(negedge CLOCK);
        preload = 1'b0;
        for (int i = 0; i < NR; i++) mregs[i] = preval[i];
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++)
            chk($sformatf("%s_reg%0d", tag, i), 32'(regs[i]), 32'(mregs[i]));
    endtask

    // Starts at a negedge in IDLE, ends at a negedge one cycle after DONE.
    task automatic run_req(input logic [3:0] s, input logic [3:0] d, input logic ie,
                           input logic [15:0] iv, input logic inc, output obs_t o);
        o = '{default: '0};
        bif.REQ_VALID  = 1'b1;
        bif.REQ_SRC    = s;
        bif.REQ_DST    = d;
        bif.REQ_IMM_EN = ie;
        bif.REQ_IMM    = iv;
        bif.REQ_INC    = inc;
        @(posedge CLOCK);
        #1;
        bif.REQ_VALID  = 1'b0;
        bif.REQ_SRC    = 4'($urandom);
        bif.REQ_DST    = 4'($urandom);
        bif.REQ_IMM_EN = 1'($urandom);
        bif.REQ_IMM    = 16'($urandom);
        bif.REQ_INC    = 1'($urandom);
        @(negedge CLOCK);
        o.err = bif.ERROR; o.rdy1 = bif.REQ_READY; o.en1 = bif.REG_ENABLE;
        o.bus1 = DATA; o.done[0] = bif.DONE;
        if (!o.err) begin
            @(negedge CLOCK);
            o.en2 = bif.REG_ENABLE; o.rw2 = bif.REG_RW; o.bus2 = DATA; o.done[1] = bif.DONE;
            @(negedge CLOCK);
            o.cnt3 = bif.REG_COUNT; o.last3 = bif.LAST_DATA; o.done[2] = bif.DONE;
            o.idle3 = bus_idle(DATA);
        end
        @(negedge CLOCK);
    endtask

    vec_t        tv [9];
    obs_t        o;
    logic [3:0]  s, d;
    logic        ie, inc, rej, rej2;
    logic [15:0] iv, val, val2;
    logic [5:0]  rpat, dpat;

    initial begin
        bif.REQ_VALID = 1'b0; bif.REQ_SRC = '0; bif.REQ_DST = '0;
        bif.REQ_IMM_EN = 1'b0; bif.REQ_IMM = '0; bif.REQ_INC = 1'b0;

        //        s     d     ie    iv        inc   err   en1    en2    rw2    cnt3   bus        cidx  cval
        tv[0] = '{4'd3, 4'd5, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h08, 8'h28, 8'hDF, 8'h00, 16'h00A5, 4'd3, 16'h00A5};
        tv[1] = '{4'd0, 4'd2, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h01, 8'h05, 8'hFB, 8'h01, 16'h0010, 4'd0, 16'h0011};
        tv[2] = '{4'd7, 4'd0, 1'b1, 16'hBEEF, 1'b1, 1'b0, 8'h00, 8'h01, 8'hFE, 8'h00, 16'hBEEF, 4'd7, 16'h7777};
        tv[3] = '{4'd4, 4'd4, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 16'h0000, 4'd4, 16'h4444};
        tv[4] = '{4'd1, 4'd9, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 16'h0000, 4'd1, 16'h1111};
        tv[5] = '{4'd2, 4'd8, 1'b1, 16'h1234, 1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 16'h0000, 4'd2, 16'h0010};
        tv[6] = '{4'd12,4'd1, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 16'h0000, 4'd1, 16'h1111};
        tv[7] = '{4'd5, 4'd6, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h20, 8'h60, 8'hBF, 8'h20, 16'h00A5, 4'd5, 16'h00A6};
        tv[8] = '{4'd8, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 16'h0000, 4'd0, 16'hBEEF};

        preval = '{16'h0010, 16'h1111, 16'h2222, 16'h00A5, 16'h4444, 16'h5555, 16'h6666, 16'h7777};

        // Reset state
        @(negedge CLOCK);
        load_regs();
        @(negedge CLOCK);
        chk("rst_enable", 32'(bif.REG_ENABLE), 32'h00);
        chk("rst_rw",     32'(bif.REG_RW),     32'hFF);
        chk("rst_count",  32'(bif.REG_COUNT),  32'h00);
        chk("rst_done",   32'(bif.DONE),       32'h0);
        chk("rst_error",  32'(bif.ERROR),      32'h0);
        chk("rst_last",   32'(bif.LAST_DATA),  32'h0);
        chk("rst_bus_z",  32'(bus_idle(DATA)), 32'h1);
        RESET = 1'b1;
        @(negedge CLOCK);
        chk("rst_ready",  32'(bif.REQ_READY),  32'h1);
        chk("rst_done2",  32'(bif.DONE),       32'h0);

        // Directed table
        for (int k = 0; k < 9; k++) begin
            model_xfer(tv[k].s, tv[k].d, tv[k].ie, tv[k].iv, tv[k].inc, rej, val);
            run_req(tv[k].s, tv[k].d, tv[k].ie, tv[k].iv, tv[k].inc, o);
            chk($sformatf("v%0d_err", k), 32'(o.err), 32'(tv[k].err));
            chk($sformatf("v%0d_en1", k), 32'(o.en1), 32'(tv[k].en1));
            if (tv[k].err) begin
                chk($sformatf("v%0d_ready", k), 32'(o.rdy1), 32'h1);
                chk($sformatf("v%0d_done", k),  32'(o.done), 32'h0);
            end else begin
                chk($sformatf("v%0d_ready", k), 32'(o.rdy1),  32'h0);
                chk($sformatf("v%0d_en2", k),   32'(o.en2),   32'(tv[k].en2));
                chk($sformatf("v%0d_rw2", k),   32'(o.rw2),   32'(tv[k].rw2));
                chk($sformatf("v%0d_count", k), 32'(o.cnt3),  32'(tv[k].cnt3));
                chk($sformatf("v%0d_bus1", k),  32'(o.bus1),  32'(tv[k].bus));
                chk($sformatf("v%0d_bus2", k),  32'(o.bus2),  32'(tv[k].bus));
                chk($sformatf("v%0d_last", k),  32'(o.last3), 32'(tv[k].bus));
                chk($sformatf("v%0d_done", k),  32'(o.done),  32'b100);
                chk($sformatf("v%0d_busz", k),  32'(o.idle3), 32'h1);
                chk($sformatf("v%0d_dst", k),   32'(regs[tv[k].d[2:0]]), 32'(tv[k].bus));
            end
            chk($sformatf("v%0d_cval", k), 32'(regs[tv[k].cidx[2:0]]), 32'(tv[k].cval));
            check_regs($sformatf("v%0d", k));
        end

        // Randomized transfers against the register-file model
        for (int i = 0; i < NR; i++) preval[i] = 16'($urandom);
        load_regs();
        for (int k = 0; k < 60; k++) begin
            s   = 4'($urandom_range(0, 9));
            d   = 4'($urandom_range(0, 9));
            ie  = ($urandom_range(0, 3) == 0);
            iv  = 16'($urandom);
            inc = 1'($urandom);
            model_xfer(s, d, ie, iv, inc, rej, val);
            run_req(s, d, ie, iv, inc, o);
            chk("rnd_err", 32'(o.err), 32'(rej));
            if (rej) begin
                chk("rnd_rej_en",   32'(o.en1),  32'h0);
                chk("rnd_rej_done", 32'(o.done), 32'h0);
            end else begin
                chk("rnd_en1",   32'(o.en1),   ie ? 32'h0 : 32'(8'(1) << s));
                chk("rnd_count", 32'(o.cnt3),  (inc && !ie) ? 32'(8'(1) << s) : 32'h0);
                chk("rnd_bus",   32'(o.bus1),  32'(val));
                chk("rnd_last",  32'(o.last3), 32'(val));
                chk("rnd_done",  32'(o.done),  32'b100);
            end
            check_regs("rnd");
        end

        // Back-to-back with REQ_VALID held: second request taken in the DONE cycle
        model_xfer(4'd1, 4'd6, 1'b0, 16'h0, 1'b0, rej, val);
        model_xfer(4'd6, 4'd7, 1'b0, 16'h0, 1'b0, rej2, val2);
        bif.REQ_VALID = 1'b1; bif.REQ_SRC = 4'd1; bif.REQ_DST = 4'd6;
        bif.REQ_IMM_EN = 1'b0; bif.REQ_INC = 1'b0;
        rpat = '0; dpat = '0;
        @(posedge CLOCK);
        #1;
        bif.REQ_SRC = 4'd6; bif.REQ_DST = 4'd7;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLOCK);
            rpat[c] = bif.REQ_READY;
            dpat[c] = bif.DONE;
        end
        bif.REQ_VALID = 1'b0;
        chk("b2b_ready", 32'(rpat), 32'b100100);
        chk("b2b_done",  32'(dpat), 32'b100100);
        chk("b2b_last",  32'(bif.LAST_DATA), 32'(val2));
        @(negedge CLOCK);
        chk("b2b_done_end", 32'(bif.DONE), 32'h0);
        check_regs("b2b");

        // Reset asserted during CAPTURE abandons the transfer
        bif.REQ_VALID = 1'b1; bif.REQ_SRC = 4'd2; bif.REQ_DST = 4'd3;
        bif.REQ_IMM_EN = 1'b0; bif.REQ_INC = 1'b1;
        @(posedge CLOCK);
        #1;
        bif.REQ_VALID = 1'b0;
        @(negedge CLOCK);
        @(negedge CLOCK);
        chk("mrst_cap_en", 32'(bif.REG_ENABLE), 32'h0C);
        RESET = 1'b0;
        #1;
        chk("mrst_en_now", 32'(bif.REG_ENABLE), 32'h00);
        @(negedge CLOCK);
        chk("mrst_en",    32'(bif.REG_ENABLE), 32'h00);
        chk("mrst_rw",    32'(bif.REG_RW),     32'hFF);
        chk("mrst_count", 32'(bif.REG_COUNT),  32'h00);
        chk("mrst_done",  32'(bif.DONE),       32'h0);
        chk("mrst_last",  32'(bif.LAST_DATA),  32'h0);
        chk("mrst_bus_z", 32'(bus_idle(DATA)), 32'h1);
        RESET = 1'b1;
        @(negedge CLOCK);
        chk("mrst_ready", 32'(bif.REQ_READY), 32'h1);
        chk("mrst_done2", 32'(bif.DONE),      32'h0);
        check_regs("mrst");

        // Recovery after reset
        model_xfer(4'd1, 4'd4, 1'b0, 16'h0, 1'b1, rej, val);
        run_req(4'd1, 4'd4, 1'b0, 16'h0, 1'b1, o);
        chk("rec_done", 32'(o.done),  32'b100);
        chk("rec_last", 32'(o.last3), 32'(val));
        check_regs("rec");

        chk("invariants", 32'(mon_bad), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
